// File: rtl/asin_lut_search.sv
// Floor-arcsine of an IEEE-754 double via 7-step binary search over a 0..90 deg sine table.
// Result valid 9 cycles after accept, held until o_out_ready; one op in flight, i_in_valid ignored while busy.
module asin_lut_search #(
    parameter int DATA_WIDTH  = 64,
    parameter int ANGLE_WIDTH = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [DATA_WIDTH-1:0]  i_x_in,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [ANGLE_WIDTH-1:0] o_out_angle,
    output logic                   o_out_err
);

    localparam int LUT_DEPTH = 91;
    localparam int FRAC      = 120;
    localparam logic [63:0] ONE_DBL = 64'h3FF0000000000000;

    // Elaboration-time sin(k deg) in 120-bit fixed point, rounded to nearest-even double.
    function automatic logic [63:0] sin_deg_to_double(input int k);
        logic [255:0] pi_fix;
        logic [255:0] theta;
        logic [255:0] x2;
        logic [255:0] term;
        logic [255:0] acc;
        logic [255:0] mant;
        logic [255:0] rem;
        logic [255:0] half;
        logic [10:0]  expo;
        int           p;
        int           sh;
        if (k == 0) return 64'd0;
        if (k == 90) return ONE_DBL;
        pi_fix = 256'h3243F6A8885A308D313198A2E037073;
        theta  = (pi_fix * 256'(k)) / 256'd180;
        x2     = (theta * theta) >> FRAC;
        term   = theta;
        acc    = theta;
        for (int n = 1; n <= 24; n++) begin
            term = ((term * x2) >> FRAC) / 256'(2 * n * (2 * n + 1));
            if ((n % 2) == 1) acc = acc - term;
            else              acc = acc + term;
        end
        p = FRAC + 1;
        while (p > 0 && (acc >> p) == 256'd0) p--;
        sh   = p - 52;
        mant = acc >> sh;
        rem  = acc - (mant << sh);
        half = 256'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 256'd1;
        if ((mant >> 53) != 256'd0) begin
            mant = mant >> 1;
            p    = p + 1;
        end
        expo = 11'(p - FRAC + 1023);
        return {1'b0, expo, mant[51:0]};
    endfunction

    logic [63:0] w_lut [0:LUT_DEPTH-1];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        localparam logic [63:0] LUT_VAL = sin_deg_to_double(g);
        assign w_lut[g] = LUT_VAL;
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SEARCH,
        S_FINAL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                   r_sign;
    logic [63:0]            r_a;
    logic                   r_err;
    logic [6:0]             r_lo;
    logic [6:0]             r_hi;
    logic [2:0]             r_iter;
    logic                   r_out_valid;
    logic [ANGLE_WIDTH-1:0] r_out_angle;
    logic                   r_out_err;

    logic [7:0]             w_sum;
    logic [6:0]             w_mid;
    logic [ANGLE_WIDTH-1:0] w_lo_ext;

    assign w_sum    = {1'b0, r_lo} + {1'b0, r_hi} + 8'd1;
    assign w_mid    = 7'(w_sum >> 1);
    assign w_lo_ext = ANGLE_WIDTH'(r_lo);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_in_valid) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = S_SEARCH;
            S_SEARCH: if (r_iter == 3'd6) w_state_nxt = S_FINAL;
            S_FINAL:  w_state_nxt = S_DONE;
            S_DONE:   if (i_out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Sign is stripped up front; the search only ever sees a non-negative magnitude.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign      <= 1'b0;
            r_a         <= '0;
            r_err       <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_iter      <= '0;
            r_out_valid <= 1'b0;
            r_out_angle <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_sign <= i_x_in[DATA_WIDTH-1];
                        r_a    <= {1'b0, i_x_in[DATA_WIDTH-2:0]};
                    end
                end
                S_CHECK: begin
                    r_err  <= (r_a > ONE_DBL);
                    r_lo   <= 7'd0;
                    r_hi   <= 7'd90;
                    r_iter <= 3'd0;
                end
                S_SEARCH: begin
                    if (w_lut[w_mid] <= r_a) r_lo <= w_mid;
                    else                     r_hi <= w_mid - 7'd1;
                    r_iter <= r_iter + 3'd1;
                end
                S_FINAL: begin
                    r_out_valid <= 1'b1;
                    r_out_err   <= r_err;
                    r_out_angle <= r_err ? '0 : (r_sign ? -w_lo_ext : w_lo_ext);
                end
                S_DONE: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_angle = r_out_angle;
    assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_asin_lut_search.sv
// Directed bench for asin_lut_search: boundaries, latency, stall, reset and a +/- sweep around every table entry.
module tb_asin_lut_search;

    logic        i_clk;
    logic        i_rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [63:0] i_x_in;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [9:0]  o_out_angle;
    logic        o_out_err;

    int n_checks;
    int n_fail;

    localparam real PI = 3.14159265358979323846;

    asin_lut_search #(.DATA_WIDTH(64), .ANGLE_WIDTH(10)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_x_in      (i_x_in),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_angle (o_out_angle),
        .o_out_err   (o_out_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Accept one operand, check latency, result, optional stall stability, and handshake release.
    task automatic run_op(input logic [63:0] x, input logic [9:0] exp_ang, input logic exp_err,
                          input int hold, input string tag);
        int cyc;
        cyc = 0;
        while (o_in_ready !== 1'b1 && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        check({tag, " ready"}, 64'(o_in_ready), 64'd1);
        i_in_valid = 1'b1;
        i_x_in     = x;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_x_in     = {$urandom, $urandom};
        cyc = 0;
        while (cyc < 20) begin
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            if (cyc == 1) check({tag, " busy"}, 64'(o_in_ready), 64'd0);
            if (o_out_valid === 1'b1) break;
        end
        check({tag, " latency"}, 64'(cyc), 64'd9);
        check({tag, " angle"}, 64'(o_out_angle), 64'(exp_ang));
        check({tag, " err"}, 64'(o_out_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check({tag, " hold valid"}, 64'(o_out_valid), 64'd1);
            check({tag, " hold angle"}, 64'(o_out_angle), 64'(exp_ang));
            check({tag, " hold err"}, 64'(o_out_err), 64'(exp_err));
        end
        i_out_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_out_ready = 1'b0;
        check({tag, " released"}, 64'(o_out_valid), 64'd0);
        check({tag, " idle again"}, 64'(o_in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] b;
        logic [63:0] xv;
        logic [9:0]  ang;
        logic        seen_valid;
        real         r;

        n_checks    = 0;
        n_fail      = 0;
        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_x_in      = '0;
        i_out_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("reset in_ready", 64'(o_in_ready), 64'd1);
        check("reset out_valid", 64'(o_out_valid), 64'd0);
        check("reset out_angle", 64'(o_out_angle), 64'd0);
        check("reset out_err", 64'(o_out_err), 64'd0);

        run_op(64'h3FE0000000000000, 10'd30,   1'b0, 0, "half");
        run_op(64'h3FDFFFFFFFFFFFFF, 10'd29,   1'b0, 0, "half-ulp");
        run_op(64'hBFE0000000000000, 10'h3E2,  1'b0, 0, "neg half");
        run_op(64'h3FF0000000000000, 10'd90,   1'b0, 0, "one");
        run_op(64'hBFF0000000000000, 10'h3A6,  1'b0, 0, "neg one");
        run_op(64'h8000000000000000, 10'd0,    1'b0, 0, "neg zero");
        run_op(64'h0000000000000000, 10'd0,    1'b0, 0, "zero");
        run_op(64'h0000000000000001, 10'd0,    1'b0, 0, "denormal");
        run_op(64'h3FF0000000000001, 10'd0,    1'b1, 0, "one+ulp");
        run_op(64'h7FF0000000000000, 10'd0,    1'b1, 0, "inf");
        run_op(64'hFFF0000000000000, 10'd0,    1'b1, 0, "neg inf");
        run_op(64'h7FF8000000000000, 10'd0,    1'b1, 0, "nan");
        run_op(64'hBFE0000000000000, 10'h3E2,  1'b0, 5, "stall");

        // Reset collides with a valid input: nothing may be accepted.
        @(negedge i_clk);
        i_rst      = 1'b1;
        i_in_valid = 1'b1;
        i_x_in     = 64'h3FE0000000000000;
        @(posedge i_clk);
        #1;
        i_rst      = 1'b0;
        i_in_valid = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("rst+valid no result", 64'(seen_valid), 64'd0);
        check("rst+valid ready", 64'(o_in_ready), 64'd1);

        // Reset lands during the third search step.
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_x_in     = 64'h3FE0000000000000;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mid rst ready", 64'(o_in_ready), 64'd1);
        check("mid rst valid", 64'(o_out_valid), 64'd0);
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("mid rst no result", 64'(seen_valid), 64'd0);
        run_op(64'hBFE0000000000000, 10'h3E2, 1'b0, 0, "after rst");

        // A few ulps either side of each entry pins the floor boundary without needing exact table bits.
        for (int k = 1; k <= 89; k++) begin
            r  = $sin(real'(k) * PI / 180.0);
            b  = $realtobits(r);
            xv = b + 64'd4;
            ang = 10'(k);
            run_op(xv, ang, 1'b0, 0, $sformatf("sweep +%0d up", k));
            run_op({1'b1, xv[62:0]}, -ang, 1'b0, 0, $sformatf("sweep -%0d up", k));
            xv = b - 64'd4;
            ang = 10'(k - 1);
            run_op(xv, ang, 1'b0, 0, $sformatf("sweep +%0d dn", k));
            run_op({1'b1, xv[62:0]}, -ang, 1'b0, 0, $sformatf("sweep -%0d dn", k));
        end
        run_op(64'h3FEFFFFFFFFFFFFC, 10'd89, 1'b0, 0, "below one");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
